uart_digest_rx: RTL and testbench



---
 rtl/md5_hbf_pkg.sv | 17 +
 rtl/uart_rx_byte.sv | 127 ++++++++++++
 rtl/uart_digest_rx.sv | 94 +++++++++
 tb/tb_uart_digest_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_hbf_pkg.sv
// Shared widths and the receive FSM state type for the MD5 brute-force board's
// UART digest receive path.
package md5_hbf_pkg;

  localparam int DIGEST_W     = 128;
  localparam int BYTE_W       = 8;
  localparam int DIGEST_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, bit timer and framing FSM.
// Emits one-cycle pulses for an accepted byte or a bad stop bit.
module uart_rx_byte
  import md5_hbf_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic [BYTE_W-1:0] data,
  output logic              byte_strobe,
  output logic              frame_error,
  output logic              rx_active
);

  localparam int DIV     = CLK_HZ / BAUD;
  localparam int HALF    = DIV / 2;
  localparam int TIMER_W = $clog2(DIV + 1);

  rx_state_t           state_reg;
  logic                rx_meta_reg;
  logic                rxs_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic [2:0]          bit_reg;
  logic [BYTE_W-1:0]   shift_reg;
  logic [BYTE_W-1:0]   data_reg;
  logic                strobe_reg;
  logic                frame_error_reg;
  logic                active_reg;

  logic half_hit;
  logic full_hit;

  assign half_hit = (timer_reg == TIMER_W'(HALF - 1));
  assign full_hit = (timer_reg == TIMER_W'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_reg     <= 1'b1;
      rxs_reg         <= 1'b1;
      state_reg       <= ST_IDLE;
      timer_reg       <= '0;
      bit_reg         <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      strobe_reg      <= 1'b0;
      frame_error_reg <= 1'b0;
      active_reg      <= 1'b0;
    end else begin
      rx_meta_reg     <= rx;
      rxs_reg         <= rx_meta_reg;
      strobe_reg      <= 1'b0;
      frame_error_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          timer_reg <= '0;
          if (!rxs_reg) begin
            state_reg  <= ST_START;
            active_reg <= 1'b1;
          end
        end
        ST_START: begin
          if (half_hit) begin
            timer_reg <= '0;
            bit_reg   <= '0;
            if (!rxs_reg) begin
              state_reg <= ST_DATA;
            end else begin
              // too short to be a start bit: treat as line noise
              state_reg  <= ST_IDLE;
              active_reg <= 1'b0;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (full_hit) begin
            timer_reg <= '0;
            shift_reg <= {rxs_reg, shift_reg[BYTE_W-1:1]};
            if (bit_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (full_hit) begin
            timer_reg <= '0;
            if (rxs_reg) begin
              data_reg   <= shift_reg;
              strobe_reg <= 1'b1;
              state_reg  <= ST_IDLE;
              active_reg <= 1'b0;
            end else begin
              frame_error_reg <= 1'b1;
              state_reg       <= ST_BREAK;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs_reg) begin
            state_reg  <= ST_IDLE;
            active_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign data        = data_reg;
  assign byte_strobe = strobe_reg;
  assign frame_error = frame_error_reg;
  assign rx_active   = active_reg;

endmodule

// File: rtl/uart_digest_rx.sv
// Assembles consecutive UART bytes into the 128-bit target digest, first byte
// in the top bits; stale partial digests are dropped after a long idle gap.
module uart_digest_rx
  import md5_hbf_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int DIGEST_BYTES = md5_hbf_pkg::DIGEST_BYTES,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           rx,
  output logic [DIGEST_BYTES*BYTE_W-1:0] digest,
  output logic                           digest_valid,
  output logic                           frame_error,
  output logic                           rx_active
);

  localparam int DW             = DIGEST_BYTES * BYTE_W;
  localparam int DIV            = CLK_HZ / BAUD;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * DIV;
  localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W          = $clog2(DIGEST_BYTES + 1);

  logic [BYTE_W-1:0] rx_data;
  logic              byte_strobe;
  logic              byte_frame_error;
  logic              byte_active;

  logic [CNT_W-1:0]  byte_count_reg;
  logic [IDLE_W-1:0] idle_count_reg;
  logic [DW-1:0]     shreg_reg;
  logic [DW-1:0]     shreg_next;
  logic [DW-1:0]     digest_reg;
  logic              digest_valid_reg;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data        (rx_data),
    .byte_strobe (byte_strobe),
    .frame_error (byte_frame_error),
    .rx_active   (byte_active)
  );

  assign shreg_next = {shreg_reg[DW-BYTE_W-1:0], rx_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_count_reg   <= '0;
      idle_count_reg   <= '0;
      shreg_reg        <= '0;
      digest_reg       <= '0;
      digest_valid_reg <= 1'b0;
    end else begin
      digest_valid_reg <= 1'b0;
      if (byte_frame_error) begin
        byte_count_reg <= '0;
        idle_count_reg <= '0;
      end else if (byte_strobe) begin
        shreg_reg      <= shreg_next;
        idle_count_reg <= '0;
        if (byte_count_reg == CNT_W'(DIGEST_BYTES - 1)) begin
          digest_reg       <= shreg_next;
          digest_valid_reg <= 1'b1;
          byte_count_reg   <= '0;
        end else begin
          byte_count_reg <= byte_count_reg + 1'b1;
        end
      end else if (!byte_active && byte_count_reg != '0) begin
        // only continuous idle counts toward dropping a half-received digest
        if (idle_count_reg == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          byte_count_reg <= '0;
          idle_count_reg <= '0;
        end else begin
          idle_count_reg <= idle_count_reg + 1'b1;
        end
      end else begin
        idle_count_reg <= '0;
      end
    end
  end

  assign digest       = digest_reg;
  assign digest_valid = digest_valid_reg;
  assign frame_error  = byte_frame_error;
  assign rx_active    = byte_active;

endmodule

// File: tb/tb_uart_digest_rx.sv
// Scoreboard bench for uart_digest_rx: a byte-level model predicts digests and
// framing errors, a monitor compares them whenever the DUT pulses.
module tb_uart_digest_rx;

  localparam int CLK_HZ       = 1000000;
  localparam int BAUD         = 62500;
  localparam int DIV          = CLK_HZ / BAUD;
  localparam int TIMEOUT_BITS = 20;

  logic         clock = 1'b0;
  logic         reset;
  logic         rx;
  logic [127:0] digest;
  logic         digest_valid;
  logic         frame_error;
  logic         rx_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dig_count = 0;
  int fe_count  = 0;
  int exp_fe    = 0;

  logic [127:0] exp_digest_q[$];
  logic [7:0]   partial_q[$];
  int           pulse_cyc_q[$];
  logic [127:0] last_digest = '0;

  uart_digest_rx #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .DIGEST_BYTES (16),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .digest       (digest),
    .digest_valid (digest_valid),
    .frame_error  (frame_error),
    .rx_active    (rx_active)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_good(input logic [7:0] b);
    logic [127:0] d;
    partial_q.push_back(b);
    if (partial_q.size() == 16) begin
      d = '0;
      for (int i = 0; i < 16; i++) d[127-8*i -: 8] = partial_q[i];
      exp_digest_q.push_back(d);
      partial_q.delete();
    end
  endtask

  task automatic model_bad();
    partial_q.delete();
    exp_fe++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (digest_valid || frame_error)
        check("valid_fe_exclusive", 128'(digest_valid & frame_error), 128'(0));
      if (digest_valid) begin
        dig_count++;
        pulse_cyc_q.push_back(cyc);
        if (exp_digest_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_digest actual=%h required=no_pulse", digest);
        end else begin
          last_digest = exp_digest_q.pop_front();
          check("digest", digest, last_digest);
        end
      end
      if (frame_error) begin
        fe_count++;
        checks++;
        if (exp_fe == 0) begin
          failures++;
          $display("FAIL unexpected_frame_error actual=1 required=0");
        end else begin
          exp_fe--;
          $display("ok   frame_error expected");
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_good(b); else model_bad();
    rx = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(DIV);
    end
    rx = stop_ok;
    wait_cyc(DIV);
    rx = 1'b1;
    if (!stop_ok) wait_cyc(2 * DIV);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    wait_cyc(n * DIV);
    if (n >= TIMEOUT_BITS) partial_q.delete();
  endtask

  initial begin
    int d0;
    int d1;
    int f0;
    logic [7:0] b;
    rx    = 1'b1;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    check("reset_digest", digest, '0);
    check("reset_valid", 128'(digest_valid), 128'(0));
    check("reset_frame_error", 128'(frame_error), 128'(0));
    check("reset_rx_active", 128'(rx_active), 128'(0));

    // 0x00..0x0F back to back
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    idle_bits(3);
    check("seq_digest", digest, 128'h000102030405060708090A0B0C0D0E0F);
    check("seq_pulses", 128'(dig_count), 128'(1));
    check("seq_no_fe", 128'(fe_count), 128'(0));

    // four good bytes, a bad stop bit, then 16 x 0xFF
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b1);
    idle_bits(3);
    check("fe_count", 128'(fe_count), 128'(1));
    check("ff_digest", digest, {128{1'b1}});
    check("ff_pulses", 128'(dig_count), 128'(2));

    // glitch shorter than half a bit
    d0 = dig_count;
    f0 = fe_count;
    rx = 1'b0;
    wait_cyc(5);
    check("glitch_active_high", 128'(rx_active), 128'(1));
    rx = 1'b1;
    wait_cyc(2 * DIV);
    check("glitch_active_low", 128'(rx_active), 128'(0));
    check("glitch_no_digest", 128'(dig_count), 128'(d0));
    check("glitch_no_fe", 128'(fe_count), 128'(f0));

    // seven bytes, long idle gap discards them
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
    idle_bits(25);
    for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    idle_bits(3);
    check("timeout_digest", digest, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    check("timeout_pulses", 128'(dig_count), 128'(3));

    // reset in the middle of data bit 3 of byte 9
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    b = 8'($urandom);
    rx = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_cyc(DIV);
    end
    rx = b[3];
    wait_cyc(DIV / 2);
    rx    = 1'b1;
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    partial_q.delete();
    wait_cyc(2);
    check("midreset_digest", digest, '0);
    check("midreset_rx_active", 128'(rx_active), 128'(0));
    idle_bits(2);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    idle_bits(3);
    check("post_reset_pulses", 128'(dig_count), 128'(4));

    // two digests with no gap between them
    for (int i = 0; i < 16; i++) send_byte(8'h11, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'h22, 1'b1);
    idle_bits(3);
    check("b2b_pulses", 128'(dig_count), 128'(6));
    d1 = pulse_cyc_q[pulse_cyc_q.size()-1];
    d0 = pulse_cyc_q[pulse_cyc_q.size()-2];
    check("b2b_spacing", 128'(d1 - d0), 128'(160 * DIV));
    check("b2b_digest", digest, {16{8'h22}});

    // randomized traffic: gaps, an occasional timeout or framing error
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        if (r == 2 && i == 5) idle_bits(25);
        if (r == 4 && i == int'($urandom_range(2, 10))) send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        d0 = int'($urandom_range(0, 3));
        if (d0 > 0) idle_bits(d0);
      end
    end
    // top up whatever partial digest the random run left behind
    while (partial_q.size() != 0) send_byte(8'($urandom), 1'b1);
    idle_bits(4);

    check("sb_drained", 128'(exp_digest_q.size()), 128'(0));
    check("fe_drained", 128'(exp_fe), 128'(0));
    check("digest_hold", digest, last_digest);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
